// File: rtl/spike_rate_decoder_pkg.sv
// Shared spike-path types and helpers for the neuron and decoder counters.
package snn_pkg;

    typedef logic [7:0] spike_cnt_t;

    localparam spike_cnt_t SPIKE_CNT_MAX = 8'd255;

    // Increment by one, holding at the maximum instead of wrapping.
    function automatic spike_cnt_t sat_inc8(input spike_cnt_t v);
        return (v == SPIKE_CNT_MAX) ? v : spike_cnt_t'(v + 8'd1);
    endfunction

endpackage

// File: rtl/spike_rate_decoder_isi_meter.sv
// Inter-spike interval meter: counts ticks since the last spike and reports
// the saturating interval on every spike after the first.
module spike_isi_meter
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       spike,
    input  logic       clear,
    output spike_cnt_t isi,
    output logic       isi_valid
);

    spike_cnt_t gap;
    logic       seen;

    // Gap counter, first-spike flag and interval output; clear wins over tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap       <= '0;
            seen      <= 1'b0;
            isi       <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (clear) begin
                gap  <= '0;
                seen <= 1'b0;
            end else if (tick) begin
                if (spike) begin
                    if (seen) begin
                        isi       <= sat_inc8(gap);
                        isi_valid <= 1'b1;
                    end
                    gap  <= '0;
                    seen <= 1'b1;
                end else begin
                    gap <= sat_inc8(gap);
                end
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train decoder: per-window spike count (rate code) and inter-spike
// interval (temporal code). Define SPIKE_DEC_EMA_EN to smooth the rate with
// an exponential moving average of shift EMA_SHIFT.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int unsigned WINDOW    = 16,
    parameter int unsigned EMA_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       spike,
    input  logic       clear,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic [7:0] isi,
    output logic       isi_valid,
    output logic       active
);

    localparam spike_cnt_t WIN_LAST = 8'(WINDOW - 1);

    spike_cnt_t wcnt;
    spike_cnt_t cnt;
    spike_cnt_t win_c;
    spike_cnt_t rate_next_c;
    logic       tick_c;
    logic       closing_c;

    // Tick qualification and the count including the current tick's spike.
    always_comb begin
        tick_c    = en & ~clear;
        closing_c = tick_c && (wcnt == WIN_LAST);
        win_c     = spike ? sat_inc8(cnt) : cnt;
    end

`ifdef SPIKE_DEC_EMA_EN
    logic              primed;
    logic signed [8:0] diff_c;
    logic signed [8:0] step_c;
    logic signed [8:0] sum_c;

    // EMA update; the first window after reset or clear loads directly.
    always_comb begin
        diff_c      = $signed({1'b0, win_c}) - $signed({1'b0, rate});
        step_c      = diff_c >>> EMA_SHIFT;
        sum_c       = $signed({1'b0, rate}) + step_c;
        rate_next_c = primed ? 8'(unsigned'(sum_c)) : win_c;
    end

    // Primed flag marks that the EMA holds a real window value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed <= 1'b0;
        end else if (clear) begin
            primed <= 1'b0;
        end else if (closing_c) begin
            primed <= 1'b1;
        end
    end
`else
    logic unused_ema_shift_c;

    // Rate is the raw window count; the smoothing shift has no effect here.
    always_comb begin
        rate_next_c        = win_c;
        unused_ema_shift_c = ^8'(EMA_SHIFT);
    end
`endif

    // Window counter, spike count and rate output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            cnt        <= '0;
            active     <= 1'b0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (clear) begin
                wcnt   <= '0;
                cnt    <= '0;
                active <= 1'b0;
            end else if (tick_c) begin
                if (closing_c) begin
                    wcnt       <= '0;
                    cnt        <= '0;
                    active     <= 1'b0;
                    rate       <= rate_next_c;
                    rate_valid <= 1'b1;
                end else begin
                    wcnt   <= spike_cnt_t'(wcnt + 8'd1);
                    cnt    <= win_c;
                    active <= (win_c != 8'd0);
                end
            end
        end
    end

    spike_isi_meter u_isi (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (en),
        .spike     (spike),
        .clear     (clear),
        .isi       (isi),
        .isi_valid (isi_valid)
    );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder against a tick-level model.
module tb_spike_rate_decoder;

    localparam int WINDOW    = 16;
    localparam int EMA_SHIFT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       spike;
    logic       clear;
    logic [7:0] rate;
    logic       rate_valid;
    logic [7:0] isi;
    logic       isi_valid;
    logic       active;

    int checks = 0;
    int passed = 0;

    // Model state: ticks/spikes in the open window, absolute tick of last spike.
    int m_wticks, m_wspk, m_tick, m_last;
    bit m_seen, m_primed;
    int e_rate, e_isi;
    bit e_rv, e_iv, e_active;

    spike_rate_decoder #(.WINDOW(WINDOW), .EMA_SHIFT(EMA_SHIFT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike      (spike),
        .clear      (clear),
        .rate       (rate),
        .rate_valid (rate_valid),
        .isi        (isi),
        .isi_valid  (isi_valid),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_wticks = 0; m_wspk = 0; m_tick = 0; m_last = 0;
        m_seen = 0; m_primed = 0;
        e_rate = 0; e_isi = 0; e_rv = 0; e_iv = 0; e_active = 0;
    endtask

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Expected outputs after the next clock edge for the given inputs.
    task automatic model_step(input bit e, input bit s, input bit c);
        int win;
        e_rv = 0;
        e_iv = 0;
        if (c) begin
            m_wticks = 0; m_wspk = 0; m_seen = 0; m_primed = 0;
        end else if (e) begin
            m_tick++;
            if (s) begin
                if (m_seen) begin
                    e_isi = min255(m_tick - m_last);
                    e_iv  = 1;
                end
                m_last = m_tick;
                m_seen = 1;
            end
            m_wticks++;
            if (s) m_wspk++;
            if (m_wticks == WINDOW) begin
                win = min255(m_wspk);
`ifdef SPIKE_DEC_EMA_EN
                if (!m_primed) begin
                    e_rate   = win;
                    m_primed = 1;
                end else begin
                    e_rate = e_rate + ((win - e_rate) >>> EMA_SHIFT);
                end
`else
                e_rate = win;
`endif
                e_rv     = 1;
                m_wticks = 0;
                m_wspk   = 0;
            end
        end
        e_active = (m_wspk > 0);
    endtask

    task automatic compare_all();
        check("rate", int'(rate), e_rate);
        check("rate_valid", int'(rate_valid), int'(e_rv));
        check("isi", int'(isi), e_isi);
        check("isi_valid", int'(isi_valid), int'(e_iv));
        check("active", int'(active), int'(e_active));
    endtask

    // One clock: drive inputs, advance the model, compare on the falling edge.
    task automatic cycle(input bit e, input bit s, input bit c);
        en = e; spike = s; clear = c;
        model_step(e, s, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n, input bit s);
        for (int i = 0; i < n; i++) cycle(1'b1, s, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; spike = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        check("reset_rate_lit", int'(rate), 0);

        // Rate of 8: spike on every other tick, with idle cycles mixed in.
        for (int i = 1; i <= WINDOW; i++) begin
            cycle(1'b1, (i % 2) == 1, 1'b0);
            if (i % 5 == 0) cycle(1'b0, 1'b1, 1'b0);
        end
        check("rate8_valid_lit", int'(rate_valid), 1);
`ifndef SPIKE_DEC_EMA_EN
        check("rate8_lit", int'(rate), 8);
`endif
        cycle(1'b0, 1'b0, 1'b0);
        check("rate8_active_after_lit", int'(active), 0);

        // Spike only on the closing tick, then an empty window.
        ticks(WINDOW - 1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
`ifndef SPIKE_DEC_EMA_EN
        check("rate1_lit", int'(rate), 1);
`endif
        ticks(WINDOW, 1'b0);
        check("rate0_valid_lit", int'(rate_valid), 1);
`ifndef SPIKE_DEC_EMA_EN
        check("rate0_lit", int'(rate), 0);
`endif

        // ISI: spikes at ticks 3, 4 and 10 after a clear.
        cycle(1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 10; t++) begin
            cycle(1'b1, (t == 3) || (t == 4) || (t == 10), 1'b0);
            if (t == 3) check("isi_first_novalid_lit", int'(isi_valid), 0);
            if (t == 4) check("isi1_lit", int'(isi), 1);
            if (t == 10) check("isi6_lit", int'(isi), 6);
        end
        ticks(300, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("isi_sat_lit", int'(isi), 255);
        check("isi_sat_valid_lit", int'(isi_valid), 1);

        // Clear together with the closing tick suppresses the pulse.
        cycle(1'b0, 1'b0, 1'b1);
        ticks(WINDOW - 1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check("clear_prio_novalid_lit", int'(rate_valid), 0);
        ticks(WINDOW - 1, 1'b0);
        check("clear_prio_quiet_lit", int'(rate_valid), 0);
        cycle(1'b1, 1'b0, 1'b0);
        check("clear_prio_next_valid_lit", int'(rate_valid), 1);

`ifdef SPIKE_DEC_EMA_EN
        // EMA: window counts 16, 0, 0 after a clear.
        cycle(1'b0, 1'b0, 1'b1);
        ticks(WINDOW, 1'b1);
        check("ema16_lit", int'(rate), 16);
        ticks(WINDOW, 1'b0);
        check("ema12_lit", int'(rate), 12);
        ticks(WINDOW, 1'b0);
        check("ema9_lit", int'(rate), 9);
`endif

        // Asynchronous reset mid-window with five spikes counted.
        cycle(1'b0, 1'b0, 1'b1);
        ticks(5, 1'b1);
        en = 1'b0; spike = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_rate_lit", int'(rate), 0);
        check("areset_isi_lit", int'(isi), 0);
        check("areset_active_lit", int'(active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        ticks(WINDOW - 3, 1'b0);
        ticks(3, 1'b1);
`ifndef SPIKE_DEC_EMA_EN
        check("after_reset_rate3_lit", int'(rate), 3);
`endif
        check("after_reset_valid_lit", int'(rate_valid), 1);

        // Randomized traffic with occasional clears and bursts.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
